// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioner.
//   BTN_FASTER / BTN_SLOWER : channel index constants
//   BTN_CNT_W               : debounce counter width
//   btn_state_t             : per-channel press FSM state
// -----------------------------------------------------------------------------
package btn_pkg;

  localparam int BTN_FASTER = 0;
  localparam int BTN_SLOWER = 1;
  localparam int BTN_CNT_W  = 24;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } btn_state_t;

endpackage : btn_pkg

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-flop synchroniser, debounce counter, press FSM and,
// when BTN_AUTO_REPEAT_EN is defined, a hold timer that requests repeat
// pulses while the button stays pressed.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   raw          in   raw asynchronous button pin (active high)
//   stable       out  debounced level (registered)
//   press_req    out  combinational request; the top registers the granted
//                     request so the pulse appears on the same edge that
//                     stable rises
//   cnt_nz_next  out  debounce counter will be non-zero after this edge
// -----------------------------------------------------------------------------
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic press_req,
  output logic cnt_nz_next
);

  if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > (1 << BTN_CNT_W) - 1 ||
      REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_params
    $error("btn_debounce_ch: parameter out of range");
  end

  localparam logic [BTN_CNT_W-1:0] DB_LAST = BTN_CNT_W'(DEBOUNCE_CYCLES);

  logic                 r_sync_ff1;
  logic                 r_sync;
  logic [BTN_CNT_W-1:0] r_cnt;
  logic                 r_stable;
  btn_state_t           r_state;

  logic [BTN_CNT_W-1:0] w_cnt_inc;
  logic [BTN_CNT_W-1:0] w_cnt_next;
  logic                 w_stable_next;
  logic                 w_rise;
  logic                 w_fall;
  btn_state_t           w_state_next;
  logic                 w_rep_req;

  // Synchroniser, counter and debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_ff1 <= 1'b0;
      r_sync     <= 1'b0;
      r_cnt      <= '0;
      r_stable   <= 1'b0;
    end else begin
      r_sync_ff1 <= raw;
      r_sync     <= r_sync_ff1;
      r_cnt      <= w_cnt_next;
      r_stable   <= w_stable_next;
    end
  end

  assign w_cnt_inc = r_cnt + BTN_CNT_W'(1);

  // The new level is accepted on the edge where the count would reach
  // DEBOUNCE_CYCLES; the counter clears instead of holding that value.
  always_comb begin
    w_cnt_next    = '0;
    w_stable_next = r_stable;
    if (r_sync != r_stable) begin
      if (w_cnt_inc == DB_LAST) begin
        w_stable_next = r_sync;
      end else begin
        w_cnt_next = w_cnt_inc;
      end
    end
  end

  assign w_rise      = w_stable_next & ~r_stable;
  assign w_fall      = ~w_stable_next & r_stable;
  assign cnt_nz_next = (w_cnt_next != '0);
  assign stable      = r_stable;

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_state_next = PRESSED;
      PRESSED: if (w_fall) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM: outputs. Only the IDLE->PRESSED transition (plus optional repeats)
  // requests a pulse; release is silent.
  always_comb begin
    press_req = w_rep_req;
    if (r_state == IDLE && w_rise) begin
      press_req = 1'b1;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  logic [31:0] r_hold;
  logic        r_rep_phase;  // 0: waiting for first repeat, 1: periodic
  logic [31:0] w_hold_inc;
  logic [31:0] w_hold_target;

  assign w_hold_inc    = r_hold + 32'd1;
  assign w_hold_target = r_rep_phase ? REPEAT_PERIOD : REPEAT_DELAY;

  // Timer is 0 on the edge the channel enters PRESSED (the initial pulse
  // edge), so a match on w_hold_inc lands exactly DELAY/PERIOD edges later.
  // A repeat on the same edge as the debounced release is suppressed.
  assign w_rep_req = (r_state == PRESSED) && w_stable_next &&
                     (w_hold_inc == w_hold_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b0;
    end else if (r_state != PRESSED || !w_stable_next) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_rep_req) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b1;
    end else begin
      r_hold      <= w_hold_inc;
    end
  end
`else
  assign w_rep_req = 1'b0;
`endif

endmodule : btn_debounce_ch

// File: rtl/btn_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// btn_pulse_conditioner
// Synchronises and debounces N_BTN raw push-buttons and emits one single-cycle
// pulse per press. Simultaneous requests are arbitrated lowest-index-wins;
// losing requests are dropped. Optional auto-repeat: define
// BTN_AUTO_REPEAT_EN.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   btn_raw     in   [N_BTN] raw button pins, active high
//   btn_stable  out  [N_BTN] debounced levels
//   btn_pulse   out  [N_BTN] one-cycle press strobes, at most one bit high
//   btn_busy    out  any debounce counter non-zero (debug)
// -----------------------------------------------------------------------------
module btn_pulse_conditioner
  import btn_pkg::*;
#(
  parameter int          N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             btn_busy
);

  logic [N_BTN-1:0] w_stable;
  logic [N_BTN-1:0] w_press_req;
  logic [N_BTN-1:0] w_cnt_nz_next;
  logic [N_BTN-1:0] w_grant;
  logic [N_BTN-1:0] r_pulse;
  logic             r_busy;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw         (btn_raw[gi]),
      .stable      (w_stable[gi]),
      .press_req   (w_press_req[gi]),
      .cnt_nz_next (w_cnt_nz_next[gi])
    );
  end

  // Isolate the lowest set request bit (x & -x).
  assign w_grant = w_press_req & (~w_press_req + N_BTN'(1));

  // Registering the next-cycle counter status makes btn_busy track the
  // counters themselves without a combinational output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_pulse <= w_grant;
      r_busy  <= |w_cnt_nz_next;
    end
  end

  assign btn_stable = w_stable;
  assign btn_pulse  = r_pulse;
  assign btn_busy   = r_busy;

endmodule : btn_pulse_conditioner

// File: tb/tb_btn_pulse_conditioner.sv
// Directed bench for btn_pulse_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8). Expected pulses are queued with their cycle numbers when
// stimulus is driven; a negedge monitor pops and compares them.
module tb_btn_pulse_conditioner;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_stable;
  logic [1:0] btn_pulse;
  logic       btn_busy;

  btn_pulse_conditioner #(
    .N_BTN           (2),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_stable (btn_stable),
    .btn_pulse  (btn_pulse),
    .btn_busy   (btn_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } exp_t;
  exp_t exp_q[$];

  int e, f, g;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_exp(input int c, input logic [1:0] v);
    exp_t x;
    x.cyc = c;
    x.val = v;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  // Scoreboard monitor: a raw press before edge e+1 must pulse in cycle e+DB+2.
  always @(negedge clk) begin : mon
    exp_t m;
    if (btn_pulse !== 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        assert (btn_pulse === 2'b00) else begin
          errors++;
          $error("FAIL unexpected_pulse: observed %b expected 00 at cycle %0d", btn_pulse, cyc);
        end
      end else begin
        m = exp_q.pop_front();
        assert (cyc === m.cyc && btn_pulse === m.val) else begin
          errors++;
          $error("FAIL pulse: observed %b at cycle %0d expected %b at cycle %0d",
                 btn_pulse, cyc, m.val, m.cyc);
        end
        $display("pulse %b at cycle %0d (expected %b at %0d)", btn_pulse, cyc, m.val, m.cyc);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      checks++;
      m = exp_q.pop_front();
      assert (btn_pulse === m.val) else begin
        errors++;
        $error("FAIL missing_pulse: observed %b expected %b at cycle %0d", btn_pulse, m.val, m.cyc);
      end
    end
  end

  initial begin
    // Reset state
    wait_cyc(3);
    chk("reset_stable", btn_stable, 2'b00);
    chk("reset_pulse", btn_pulse, 2'b00);
    chk("reset_busy", {1'b0, btn_busy}, 2'b00);
    rst_n = 1'b1;
    wait_cyc(3);
    chk("idle_busy", {1'b0, btn_busy}, 2'b00);

    // Clean press on channel 0, then release
    e = cyc;
    btn_raw = 2'b01;
    push_exp(e + DB + 2, 2'b01);
    wait_until(e + 3);
    chk("clean_busy_high", {1'b0, btn_busy}, 2'b01);
    wait_until(e + DB + 1);
    chk("clean_stable_before", btn_stable, 2'b00);
    wait_until(e + DB + 2);
    chk("clean_stable_after", btn_stable, 2'b01);
    chk("clean_busy_low", {1'b0, btn_busy}, 2'b00);
    wait_cyc(10);
    e = cyc;
    btn_raw = 2'b00;
    wait_until(e + DB + 1);
    chk("release_stable_before", btn_stable, 2'b01);
    wait_until(e + DB + 2);
    chk("release_stable_after", btn_stable, 2'b00);
    wait_cyc(4);

    // Channel 1 alone
    e = cyc;
    btn_raw = 2'b10;
    push_exp(e + DB + 2, 2'b10);
    wait_until(e + DB + 2);
    chk("ch1_stable", btn_stable, 2'b10);
    wait_cyc(6);
    btn_raw = 2'b00;
    wait_cyc(10);

    // Bounce: toggle every 2 cycles for 20 cycles, then hold high
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0) ? 2'b01 : 2'b00;
      wait_cyc(2);
    end
    chk("bounce_stable_low", btn_stable, 2'b00);
    e = cyc;
    btn_raw = 2'b01;
    push_exp(e + DB + 2, 2'b01);
    wait_until(e + DB + 2);
    chk("bounce_stable_high", btn_stable, 2'b01);
    wait_cyc(5);
    btn_raw = 2'b00;
    wait_cyc(10);

    // Simultaneous press: only channel 0 pulses; release of both is silent
    e = cyc;
    btn_raw = 2'b11;
    push_exp(e + DB + 2, 2'b01);
    wait_until(e + DB + 2);
    chk("simul_stable", btn_stable, 2'b11);
    wait_cyc(5);
    f = cyc;
    btn_raw = 2'b00;
    wait_until(f + DB + 2);
    chk("simul_release", btn_stable, 2'b00);
    wait_cyc(6);

    // Channel 0 pressed while channel 1 is already held
    e = cyc;
    btn_raw = 2'b10;
    push_exp(e + DB + 2, 2'b10);
    wait_cyc(8);
    e = cyc;
    btn_raw = 2'b11;
    push_exp(e + DB + 2, 2'b01);
    wait_until(e + DB + 2);
    chk("stagger_stable", btn_stable, 2'b11);
    btn_raw = 2'b00;
    wait_cyc(12);

    // Reset mid-count, button still held at release
    e = cyc;
    btn_raw = 2'b01;
    wait_until(e + 4);
    chk("midcount_busy", {1'b0, btn_busy}, 2'b01);
    rst_n = 1'b0;
    wait_cyc(2);
    chk("rst_stable", btn_stable, 2'b00);
    chk("rst_pulse", btn_pulse, 2'b00);
    chk("rst_busy", {1'b0, btn_busy}, 2'b00);
    g = cyc;
    rst_n = 1'b1;
    push_exp(g + DB + 2, 2'b01);
    wait_until(g + DB + 1);
    chk("postrst_stable_before", btn_stable, 2'b00);
    wait_until(g + DB + 2);
    chk("postrst_stable_after", btn_stable, 2'b01);
    btn_raw = 2'b00;
    wait_cyc(12);

    // Long hold (60 cycles)
    e = cyc;
    btn_raw = 2'b01;
    push_exp(e + DB + 2, 2'b01);
`ifdef BTN_AUTO_REPEAT_EN
    push_exp(e + DB + 2 + 20, 2'b01);
    push_exp(e + DB + 2 + 28, 2'b01);
    push_exp(e + DB + 2 + 36, 2'b01);
    push_exp(e + DB + 2 + 44, 2'b01);
    push_exp(e + DB + 2 + 52, 2'b01);
`endif
    wait_until(e + 60);
    chk("hold_stable", btn_stable, 2'b01);
    btn_raw = 2'b00;
    wait_cyc(20);
    chk("hold_release", btn_stable, 2'b00);

    // Every queued pulse must have been seen
    wait_cyc(5);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL pending_pulses: observed %0d outstanding expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_btn_pulse_conditioner
